iro_seed_loader: RTL and testbench

- Serial master that loads the ring-oscillator seed register over the two-wire bclk/bdat shift interface, then optionally starts the oscillator.
- Captures a parallel seed word and shifts it out MSB first, so seed_in[i] ends up in the ring's seed[i] after N_STAGES rising bclk edges.
- Owns the ring's enable and hold controls, so the ring is never enabled while the seed is being shifted.
- Sits between the TT user-register/control logic and the ring-oscillator block.

---
 rtl/iro_seed_loader.sv | 129 ++++++++++++
 tb/tb_iro_seed_loader.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iro_seed_loader.sv
// Serial seed loader for the ring oscillator: shifts a captured seed MSB first over bclk/bdat,
// then optionally enables the ring. Owns the ring enable/hold so they are quiet during a load.
module iro_seed_loader #(
  parameter int unsigned N_STAGES = 25,
  parameter int unsigned DIV_W    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [N_STAGES-1:0] seed_in,
  input  logic [DIV_W-1:0]    div,
  input  logic                run_after_load,
  input  logic                stop,
  input  logic                hold_in,
  output logic                bclk,
  output logic                bdat,
  output logic                enable,
  output logic                hold,
  output logic                busy,
  output logic                done
);

  localparam int unsigned CntW = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;

  typedef enum logic [2:0] {StIdle, StLow, StHigh, StGap, StRun} state_e;

  state_e              state_q;
  logic [N_STAGES-1:0] shadow_q;
  logic [CntW-1:0]     bit_cnt_q;
  logic [DIV_W-1:0]    phase_q;
  logic [DIV_W-1:0]    div_q;
  logic                run_q;
  logic                bclk_q, bdat_q, enable_q, hold_q, busy_q, done_q;

  logic phase_end;
  logic load_req;

  assign phase_end = (phase_q == div_q);
  // stop beats start in RUN; start is ignored while a load is in flight
  assign load_req  = start && ((state_q == StIdle) || ((state_q == StRun) && !stop));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      shadow_q  <= '0;
      bit_cnt_q <= '0;
      phase_q   <= '0;
      div_q     <= '0;
      run_q     <= 1'b0;
      bclk_q    <= 1'b0;
      bdat_q    <= 1'b0;
      enable_q  <= 1'b0;
      hold_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (load_req) begin
        state_q   <= StLow;
        shadow_q  <= seed_in;
        div_q     <= div;
        run_q     <= run_after_load;
        bit_cnt_q <= CntW'(N_STAGES - 1);
        phase_q   <= '0;
        bclk_q    <= 1'b0;
        bdat_q    <= seed_in[N_STAGES-1];
        enable_q  <= 1'b0;
        hold_q    <= 1'b0;
        busy_q    <= 1'b1;
      end else begin
        unique case (state_q)
          StIdle: hold_q <= hold_in;
          StLow: begin
            if (phase_end) begin
              phase_q <= '0;
              bclk_q  <= 1'b1;
              state_q <= StHigh;
            end else begin
              phase_q <= phase_q + 1'b1;
            end
          end
          StHigh: begin
            if (phase_end) begin
              phase_q <= '0;
              bclk_q  <= 1'b0;
              if (bit_cnt_q != '0) begin
                bit_cnt_q <= bit_cnt_q - 1'b1;
                bdat_q    <= shadow_q[bit_cnt_q - 1'b1];
                state_q   <= StLow;
              end else begin
                bdat_q  <= 1'b0;
                state_q <= StGap;
              end
            end else begin
              phase_q <= phase_q + 1'b1;
            end
          end
          StGap: begin
            if (phase_end) begin
              phase_q  <= '0;
              done_q   <= 1'b1;
              busy_q   <= 1'b0;
              enable_q <= run_q;
              state_q  <= run_q ? StRun : StIdle;
            end else begin
              phase_q <= phase_q + 1'b1;
            end
          end
          StRun: begin
            hold_q <= hold_in;
            if (stop) begin
              enable_q <= 1'b0;
              state_q  <= StIdle;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign bclk   = bclk_q;
  assign bdat   = bdat_q;
  assign enable = enable_q;
  assign hold   = hold_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_iro_seed_loader.sv
// Directed bench for iro_seed_loader: reference shift register on bclk, timing of done/bclk edges.
module tb_iro_seed_loader;
  localparam int N = 25;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [N-1:0]  seed_in = '0;
  logic [DW-1:0] div = '0;
  logic          run_after_load = 1'b0;
  logic          stop = 1'b0;
  logic          hold_in = 1'b0;
  logic          bclk, bdat, enable, hold, busy, done;

  iro_seed_loader #(.N_STAGES(N), .DIV_W(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .seed_in(seed_in), .div(div),
    .run_after_load(run_after_load), .stop(stop), .hold_in(hold_in),
    .bclk(bclk), .bdat(bdat), .enable(enable), .hold(hold), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail = 0;
  int e0 = 0;

  // bclk monitor: reference shift register plus edge timestamps
  logic [N-1:0] ref_sr = '0;
  int rise_cnt = 0, fall_cnt = 0, stable_err = 0;
  int rise_t[64];
  int fall_t[64];
  logic prev_bclk = 1'b0, prev_bdat = 1'b0;

  always @(negedge clk) begin
    if (bclk === 1'b1 && prev_bclk === 1'b0) begin
      if (rise_cnt < 64) rise_t[rise_cnt] = cyc;
      ref_sr = {ref_sr[N-2:0], bdat};
      rise_cnt++;
    end
    if (bclk === 1'b0 && prev_bclk === 1'b1) begin
      if (fall_cnt < 64) fall_t[fall_cnt] = cyc;
      fall_cnt++;
    end
    if (bclk === 1'b1 && prev_bclk === 1'b1 && bdat !== prev_bdat) stable_err++;
    prev_bclk = bclk;
    prev_bdat = bdat;
  end

  task automatic do_start(input logic [N-1:0] s, input logic [DW-1:0] d, input logic r);
    @(negedge clk);
    ref_sr = '0; rise_cnt = 0; fall_cnt = 0; stable_err = 0;
    seed_in = s; div = d; run_after_load = r; start = 1'b1;
    @(posedge clk);
    #1;
    e0 = cyc;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int t);
    t = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        t = cyc - e0;
        break;
      end
    end
  endtask

  task automatic pulse_start_at(input int k, input logic [N-1:0] s);
    while (cyc < e0 + k - 1) @(negedge clk);
    start = 1'b1; seed_in = s;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    n_checks++;
    if ({bclk, bdat, enable, hold, busy, done} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b expected 000000", {bclk, bdat, enable, hold, busy, done});
    end
    rise_cnt = 0;
    stop = 1'b1; hold_in = 1'b1;
    @(negedge clk);
    stop = 1'b0; hold_in = 1'b0;
    n_checks++;
    if (hold !== 1'b1) begin
      n_fail++; $display("FAIL idle_hold_follow: got %b expected 1", hold);
    end
    repeat (5) @(negedge clk);
    n_checks++;
    if (rise_cnt !== 0 || bclk !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL idle_no_activity: rises %0d bclk %b busy %b expected 0 0 0",
                         rise_cnt, bclk, busy);
    end
  endtask

  task automatic test_shift_div0;
    int t;
    do_start(25'h1A5A5A5, 8'd0, 1'b0);
    hold_in = 1'b1;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b1 || hold !== 1'b0 || bdat !== 1'b1) begin
      n_fail++; $display("FAIL load_begin: busy %b hold %b bdat %b expected 1 0 1", busy, hold, bdat);
    end
    wait_done(200, t);
    hold_in = 1'b0;
    n_checks++;
    if (t !== 51) begin n_fail++; $display("FAIL div0_done_time: got %0d expected 51", t); end
    n_checks++;
    if (rise_cnt !== 25) begin n_fail++; $display("FAIL div0_rises: got %0d expected 25", rise_cnt); end
    n_checks++;
    if (ref_sr !== 25'h1A5A5A5) begin
      n_fail++; $display("FAIL div0_seed: got %h expected 1a5a5a5", ref_sr);
    end
    n_checks++;
    if (busy !== 1'b0 || enable !== 1'b0) begin
      n_fail++; $display("FAIL div0_end_state: busy %b enable %b expected 0 0", busy, enable);
    end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL done_pulse_width: got %b expected 0", done); end
  endtask

  task automatic test_div3;
    int t;
    do_start(25'h0000001, 8'd3, 1'b0);
    wait_done(500, t);
    n_checks++;
    if (t !== 204) begin n_fail++; $display("FAIL div3_done_time: got %0d expected 204", t); end
    n_checks++;
    if (ref_sr !== 25'h0000001) begin
      n_fail++; $display("FAIL div3_seed: got %h expected 0000001", ref_sr);
    end
    n_checks++;
    if (stable_err !== 0) begin
      n_fail++; $display("FAIL div3_bdat_stable: got %0d changes expected 0", stable_err);
    end
    n_checks++;
    if (rise_cnt !== 25 || fall_cnt !== 25) begin
      n_fail++; $display("FAIL div3_edges: rises %0d falls %0d expected 25 25", rise_cnt, fall_cnt);
    end else begin
      for (int k = 0; k < 25; k++) begin
        n_checks++;
        if (rise_t[k] - e0 !== (2 * k + 1) * 4 || fall_t[k] - e0 !== (2 * k + 2) * 4) begin
          n_fail++;
          $display("FAIL div3_phase[%0d]: rise %0d fall %0d expected %0d %0d", k,
                   rise_t[k] - e0, fall_t[k] - e0, (2 * k + 1) * 4, (2 * k + 2) * 4);
        end
      end
    end
  endtask

  task automatic test_run;
    int t, rc;
    do_start(25'h0F0F0F0, 8'd0, 1'b1);
    wait_done(200, t);
    n_checks++;
    if (t !== 51 || enable !== 1'b1) begin
      n_fail++; $display("FAIL run_enable: t %0d enable %b expected 51 1", t, enable);
    end
    hold_in = 1'b1;
    @(negedge clk);
    n_checks++;
    if (hold !== 1'b1) begin n_fail++; $display("FAIL run_hold: got %b expected 1", hold); end
    hold_in = 1'b0;
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    n_checks++;
    if (enable !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL run_stop: enable %b busy %b expected 0 0", enable, busy);
    end
    do_start(25'h1555555, 8'd0, 1'b1);
    wait_done(200, t);
    n_checks++;
    if (t !== 51 || enable !== 1'b1 || ref_sr !== 25'h1555555) begin
      n_fail++; $display("FAIL run_reload_prep: t %0d enable %b seed %h expected 51 1 1555555",
                         t, enable, ref_sr);
    end
    rc = rise_cnt;
    start = 1'b1; stop = 1'b1; seed_in = 25'h0AAAAAA;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    n_checks++;
    if (enable !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL start_stop_enable: enable %b busy %b expected 0 0", enable, busy);
    end
    repeat (6) @(negedge clk);
    n_checks++;
    if (rise_cnt !== rc || busy !== 1'b0) begin
      n_fail++; $display("FAIL start_stop_no_reload: rises %0d busy %b expected %0d 0", rise_cnt, busy, rc);
    end
  endtask

  task automatic test_back_to_back;
    int t;
    do_start(25'h1234567, 8'd0, 1'b1);
    pulse_start_at(5, 25'h1FFFFFF);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    pulse_start_at(20, 25'h0000000);
    wait_done(200, t);
    n_checks++;
    if (t !== 51) begin n_fail++; $display("FAIL ignore_done_time: got %0d expected 51", t); end
    n_checks++;
    if (ref_sr !== 25'h1234567 || enable !== 1'b1) begin
      n_fail++; $display("FAIL ignore_seed: got %h enable %b expected 1234567 1", ref_sr, enable);
    end
    do_start(25'h0C3C3C3, 8'd0, 1'b0);
    @(negedge clk);
    n_checks++;
    if (enable !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL reload_edge: enable %b busy %b expected 0 1", enable, busy);
    end
    wait_done(200, t);
    n_checks++;
    if (t !== 51 || ref_sr !== 25'h0C3C3C3 || rise_cnt !== 25) begin
      n_fail++; $display("FAIL reload_seed: t %0d seed %h rises %0d expected 51 0c3c3c3 25",
                         t, ref_sr, rise_cnt);
    end
  endtask

  task automatic test_reset_mid;
    int t;
    do_start(25'h1FFFFFF, 8'd0, 1'b1);
    while (cyc < e0 + 17) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({bclk, bdat, enable, hold, busy, done} !== 6'b0) begin
      n_fail++; $display("FAIL mid_reset_async: got %b expected 000000", {bclk, bdat, enable, hold, busy, done});
    end
    @(negedge clk);
    rst = 1'b0;
    do_start(25'h0ABCDEF, 8'd0, 1'b0);
    wait_done(200, t);
    n_checks++;
    if (t !== 51 || ref_sr !== 25'h0ABCDEF || rise_cnt !== 25) begin
      n_fail++; $display("FAIL after_reset_load: t %0d seed %h rises %0d expected 51 0abcdef 25",
                         t, ref_sr, rise_cnt);
    end
  endtask

  task automatic test_div_max;
    int t;
    do_start(25'h1C0FFEE, 8'hFF, 1'b0);
    wait_done(14000, t);
    n_checks++;
    if (t !== 51 * 256) begin n_fail++; $display("FAIL divmax_done_time: got %0d expected %0d", t, 51 * 256); end
    n_checks++;
    if (ref_sr !== 25'h1C0FFEE || rise_cnt !== 25) begin
      n_fail++; $display("FAIL divmax_seed: got %h rises %0d expected 1c0ffee 25", ref_sr, rise_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_shift_div0();
    test_div3();
    test_run();
    test_back_to_back();
    test_reset_mid();
    test_div_max();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
